// File: rtl/spatz_pkg.sv
// spatz_pkg: VRF geometry, address/data types and the VRF reader state encoding
package spatz_pkg;
  localparam int unsigned NRVREG = 32;
  localparam int unsigned VLEN   = 128;
  localparam int unsigned N_IPU  = 1;
  localparam int unsigned ELEN   = 32;
  localparam int unsigned VRF_WORDS_PER_VREG = VLEN / (N_IPU * ELEN);
  localparam int unsigned VREG_AW = $clog2(NRVREG);
  localparam int unsigned WORD_AW = $clog2(VRF_WORDS_PER_VREG);
  typedef logic [VREG_AW+WORD_AW-1:0] vreg_addr_t;
  typedef logic [N_IPU*ELEN-1:0]      vreg_data_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} vrf_reader_state_e;
endpackage

// File: rtl/spatz_vrf_reader_fifo.sv
// spatz_vrf_reader_fifo: operand buffer with flush; pop and push may coincide when full
module spatz_vrf_reader_fifo
  import spatz_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  vreg_data_t                   data_i,
  input  logic                         pop_i,
  output vreg_data_t                   data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  vreg_data_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;
  assign do_pop  = pop_i && count_q != '0;
  assign do_push = push_i && (count_q != CW'(DEPTH) || do_pop);
  assign data_o  = mem_q[rptr_q];
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/spatz_vrf_reader.sv
// spatz_vrf_reader: streams a vreg range out of one VRF read port into a valid/ready operand stream
// SPATZ_VRF_READER_BYPASS_EN: forward rdata_i straight to the operand port when the buffer is empty
module spatz_vrf_reader
  import spatz_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned VL_WIDTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [4:0]                    req_vreg_i,
  input  logic [VL_WIDTH-1:0]           req_len_i,
  input  logic                          kill_i,
  output logic [$bits(vreg_addr_t)-1:0] raddr_o,
  output logic                          re_o,
  input  logic [$bits(vreg_data_t)-1:0] rdata_i,
  input  logic                          rvalid_i,
  output logic                          op_valid_o,
  input  logic                          op_ready_i,
  output logic [$bits(vreg_data_t)-1:0] op_data_o,
  output logic                          op_last_o,
  output logic                          busy_o,
  output logic                          done_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  vrf_reader_state_e   state_q, state_d;
  vreg_addr_t          addr_q;
  vreg_data_t          fifo_data;
  logic [VL_WIDTH-1:0] remaining_q, len_q, hand_q;
  logic [CW-1:0]       inflight_q, inflight_d, discard_q, fifo_count;
  logic done_q, fifo_empty, accept, rsp, keep, bypass, push, pop, hs, fin;
  assign req_ready_o = state_q == IDLE && discard_q == '0;
  assign accept      = req_valid_i && req_ready_o && !kill_i;
  assign re_o        = state_q == ISSUE && ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_C;
  assign raddr_o     = addr_q;
  // A response is only real if something is outstanding (or leaving this very cycle)
  assign rsp         = rvalid_i && (inflight_q != '0 || re_o);
  assign keep        = rsp && discard_q == '0 && !kill_i;
`ifdef SPATZ_VRF_READER_BYPASS_EN
  assign bypass      = keep && fifo_empty && op_ready_i;
`else
  assign bypass      = 1'b0;
`endif
  assign push        = keep && !bypass;
  assign pop         = !fifo_empty && op_ready_i;
  assign op_valid_o  = !fifo_empty || bypass;
  assign op_data_o   = bypass ? rdata_i : fifo_data;
  assign hs          = op_valid_o && op_ready_i;
  assign op_last_o   = op_valid_o && hand_q == len_q - 1'b1;
  assign fin         = hs && op_last_o && state_q != IDLE && !kill_i;
  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q || fin;
  assign inflight_d  = inflight_q + CW'(re_o) - CW'(rsp);
  spatz_vrf_reader_fifo #(.DEPTH(FIFO_DEPTH)) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (kill_i),
    .push_i  (push),
    .data_i  (rdata_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  always_comb begin
    state_d = kill_i || fin ? IDLE :
              accept && req_len_i != '0 ? ISSUE :
              state_q == ISSUE && re_o && remaining_q == VL_WIDTH'(1) ? DRAIN : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      hand_q      <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      // On kill every read still outstanding belongs to the aborted request
      discard_q  <= kill_i ? inflight_d : (rsp && discard_q != '0) ? discard_q - 1'b1 : discard_q;
      done_q     <= accept && req_len_i == '0;
      if (accept) begin
        addr_q      <= {req_vreg_i, {WORD_AW{1'b0}}};
        remaining_q <= req_len_i;
        len_q       <= req_len_i;
        hand_q      <= '0;
      end else begin
        if (re_o) begin
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
        end
        if (hs) hand_q <= hand_q + 1'b1;
      end
    end
  end
endmodule
